// File: rtl/bcd_seg_scan_if.sv
// Signal bundle between the BCD time source and the multiplexed 7-segment scanner.
// The master drives the time word and display controls; the slave drives the panel.
interface bcd_seg_scan_if;
    logic        en;
    logic [23:0] bcd;
    logic [5:0]  blink;
    logic        blink_tick;
    logic        lz_blank;
    logic [5:0]  dp;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [5:0]  dig_sel;
    logic [2:0]  digit_idx;
    logic        frame_done;

    modport master (
        output en, bcd, blink, blink_tick, lz_blank, dp,
        input  seg, seg_dp, dig_sel, digit_idx, frame_done
    );

    modport slave (
        input  en, bcd, blink, blink_tick, lz_blank, dp,
        output seg, seg_dp, dig_sel, digit_idx, frame_done
    );
endinterface

// File: rtl/bcd_seg_scan.sv
// Six-digit multiplexed 7-segment scanner for an hh:mm:ss BCD word.
// The time word is snapshotted once per frame so a display frame never tears.
module bcd_seg_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seg_scan_if.slave  bus
);

    localparam int              PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0]      SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_INV  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [5:0]      DIG_INV = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    // Invalid BCD codes show a dash so a bad upstream count is visible.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    logic [PW-1:0] prescaler_r;
    logic [2:0]    idx_r;
    logic          blink_phase_r;
    logic [23:0]   frame_reg_r;
    logic          load_pending_r;
    logic [6:0]    seg_r;
    logic          seg_dp_r;
    logic [5:0]    dig_sel_r;
    logic [2:0]    digit_idx_r;
    logic          frame_done_r;

    logic          step_s;
    logic          last_digit_s;
    logic [PW-1:0] prescaler_nx_s;
    logic [2:0]    idx_nx_s;
    logic [23:0]   frame_src_s;
    logic [3:0]    digit_s;
    logic          blink_bit_s;
    logic          dp_bit_s;
    logic [5:0]    onehot_s;
    logic          phase_eff_s;
    logic          blank_s;
    logic [6:0]    seg_nx_s;
    logic          seg_dp_nx_s;
    logic [5:0]    dig_sel_nx_s;

    // Prescaler and digit index advance; both freeze while the scan is disabled.
    always_comb begin
        step_s         = 1'b0;
        prescaler_nx_s = prescaler_r;
        idx_nx_s       = idx_r;
        last_digit_s   = (idx_r == 3'd5);
        if (bus.en) begin
            if (prescaler_r == PRE_MAX) begin
                step_s         = 1'b1;
                prescaler_nx_s = '0;
                idx_nx_s       = last_digit_s ? 3'd0 : idx_r + 3'd1;
            end else begin
                prescaler_nx_s = prescaler_r + PW'(1);
            end
        end else begin
            step_s = 1'b0;
        end
    end

    // Per-digit selection; the first cycle after reset reads the live word being loaded.
    always_comb begin
        frame_src_s = load_pending_r ? bus.bcd : frame_reg_r;
        digit_s     = 4'd0;
        blink_bit_s = 1'b0;
        dp_bit_s    = 1'b0;
        onehot_s    = 6'b000000;
        case (idx_r)
            3'd0: begin digit_s = frame_src_s[3:0];   blink_bit_s = bus.blink[0]; dp_bit_s = bus.dp[0]; onehot_s = 6'b000001; end
            3'd1: begin digit_s = frame_src_s[7:4];   blink_bit_s = bus.blink[1]; dp_bit_s = bus.dp[1]; onehot_s = 6'b000010; end
            3'd2: begin digit_s = frame_src_s[11:8];  blink_bit_s = bus.blink[2]; dp_bit_s = bus.dp[2]; onehot_s = 6'b000100; end
            3'd3: begin digit_s = frame_src_s[15:12]; blink_bit_s = bus.blink[3]; dp_bit_s = bus.dp[3]; onehot_s = 6'b001000; end
            3'd4: begin digit_s = frame_src_s[19:16]; blink_bit_s = bus.blink[4]; dp_bit_s = bus.dp[4]; onehot_s = 6'b010000; end
            3'd5: begin digit_s = frame_src_s[23:20]; blink_bit_s = bus.blink[5]; dp_bit_s = bus.dp[5]; onehot_s = 6'b100000; end
            default: begin
                digit_s     = 4'd0;
                blink_bit_s = 1'b0;
                dp_bit_s    = 1'b0;
                onehot_s    = 6'b000000;
            end
        endcase
    end

    // Next panel drive; a blink tick in this cycle already affects this cycle's decision.
    always_comb begin
        phase_eff_s  = blink_phase_r ^ bus.blink_tick;
        blank_s      = (blink_bit_s && phase_eff_s) ||
                       (bus.lz_blank && last_digit_s && (digit_s == 4'd0));
        seg_nx_s     = SEG_INV;
        seg_dp_nx_s  = DP_INV;
        dig_sel_nx_s = DIG_INV;
        if (!bus.en) begin
            seg_nx_s     = SEG_INV;
            seg_dp_nx_s  = DP_INV;
            dig_sel_nx_s = DIG_INV;
        end else if (blank_s) begin
            seg_nx_s     = SEG_INV;
            seg_dp_nx_s  = DP_INV;
            dig_sel_nx_s = onehot_s ^ DIG_INV;
        end else begin
            seg_nx_s     = seg7(digit_s) ^ SEG_INV;
            seg_dp_nx_s  = dp_bit_s ^ DP_INV;
            dig_sel_nx_s = onehot_s ^ DIG_INV;
        end
    end

    // Scan state: counters, blink phase and the per-frame snapshot of the time word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_r    <= '0;
            idx_r          <= 3'd0;
            blink_phase_r  <= 1'b0;
            frame_reg_r    <= 24'h000000;
            load_pending_r <= 1'b1;
        end else begin
            prescaler_r    <= prescaler_nx_s;
            idx_r          <= idx_nx_s;
            load_pending_r <= 1'b0;
            if (bus.blink_tick) begin
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_phase_r <= blink_phase_r;
            end
            if (load_pending_r || (step_s && last_digit_s)) begin
                frame_reg_r <= bus.bcd;
            end else begin
                frame_reg_r <= frame_reg_r;
            end
        end
    end

    // Output registers; segments and selects move together so no cycle mixes digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= SEG_INV;
            seg_dp_r     <= DP_INV;
            dig_sel_r    <= DIG_INV;
            digit_idx_r  <= 3'd0;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nx_s;
            seg_dp_r     <= seg_dp_nx_s;
            dig_sel_r    <= dig_sel_nx_s;
            digit_idx_r  <= idx_r;
            frame_done_r <= step_s && last_digit_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.seg_dp     = seg_dp_r;
    assign bus.dig_sel    = dig_sel_r;
    assign bus.digit_idx  = digit_idx_r;
    assign bus.frame_done = frame_done_r;

endmodule
